// File: rtl/alu_pkg.sv
// Shared definitions for the two-requester ALU arbiter:
// ALU control encodings and the result-holding FSM states.
package alu_pkg;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_XOR = 3'b100,
        OP_SLT = 3'b101,
        OP_SLL = 3'b110,
        OP_SRL = 3'b111
    } alu_op_e;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_e;

endpackage

// File: rtl/alu.sv
// Combinational N-bit ALU: eight operations, signed set-less-than,
// logical shifts by b[4:0], plus an all-zero flag on the result.
module alu
    import alu_pkg::*;
#(
    parameter int N = 32
) (
    input  logic [N-1:0] i_a,
    input  logic [N-1:0] i_b,
    input  alu_op_e      i_op,
    output logic [N-1:0] o_y,
    output logic         o_zero
);

    logic w_lt;

    assign w_lt = $signed(i_a) < $signed(i_b);

    // Operation select; add/sub wrap naturally at N bits
    always_comb begin
        o_y = '0;
        unique case (i_op)
            OP_ADD: o_y = i_a + i_b;
            OP_SUB: o_y = i_a - i_b;
            OP_AND: o_y = i_a & i_b;
            OP_OR:  o_y = i_a | i_b;
            OP_XOR: o_y = i_a ^ i_b;
            OP_SLT: o_y = {{(N-1){1'b0}}, w_lt};
            OP_SLL: o_y = i_a << i_b[4:0];
            OP_SRL: o_y = i_a >> i_b[4:0];
            default: o_y = '0;
        endcase
    end

    assign o_zero = (o_y == '0);

endmodule

// File: rtl/alu_arbiter.sv
// Two requesters time-share one ALU under round-robin arbitration;
// one result is held in an output register until its owner consumes it.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         req0_valid,
    input  logic         req1_valid,
    output logic         req0_ready,
    output logic         req1_ready,
    input  logic [N-1:0] req0_a,
    input  logic [N-1:0] req0_b,
    input  logic [N-1:0] req1_a,
    input  logic [N-1:0] req1_b,
    input  logic [2:0]   req0_op,
    input  logic [2:0]   req1_op,
    output logic         rsp0_valid,
    output logic         rsp1_valid,
    input  logic         rsp0_ready,
    input  logic         rsp1_ready,
    output logic [N-1:0] rsp_result,
    output logic         rsp_zero
);

    state_e       r_state;
    state_e       w_state_nxt;
    logic         r_owner;
    logic         r_last;
    logic [N-1:0] r_result;
    logic         r_zero;

    logic         w_owner_ready;
    logic         w_can_accept;
    logic         w_gnt1;
    logic         w_gnt0;
    logic         w_accept;
    logic [N-1:0] w_a;
    logic [N-1:0] w_b;
    logic [2:0]   w_op;
    logic [N-1:0] w_alu_y;
    logic         w_alu_zero;

    // r_last = 1 means requester 1 was granted last, so 0 wins a tie
    assign w_gnt1 = req1_valid & (~req0_valid | ~r_last);
    assign w_gnt0 = req0_valid & ~w_gnt1;

    assign w_owner_ready = r_owner ? rsp1_ready : rsp0_ready;
    assign w_can_accept  = (r_state == IDLE) | w_owner_ready;
    assign w_accept      = reset_n & w_can_accept & (w_gnt0 | w_gnt1);

    assign req0_ready = w_accept & w_gnt0;
    assign req1_ready = w_accept & w_gnt1;

    assign w_a  = w_gnt1 ? req1_a  : req0_a;
    assign w_b  = w_gnt1 ? req1_b  : req0_b;
    assign w_op = w_gnt1 ? req1_op : req0_op;

    alu #(.N(N)) u_alu (
        .i_a    (w_a),
        .i_b    (w_b),
        .i_op   (alu_op_e'(w_op)),
        .o_y    (w_alu_y),
        .o_zero (w_alu_zero)
    );

    // Next state: a new acceptance always leaves a result held
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE: begin
                if (w_accept) w_state_nxt = HOLD;
            end
            HOLD: begin
                if (w_accept)          w_state_nxt = HOLD;
                else if (w_owner_ready) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // State, ownership, grant pointer and held result registers
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state  <= IDLE;
            r_owner  <= 1'b0;
            r_last   <= 1'b1;
            r_result <= '0;
            r_zero   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_owner  <= w_gnt1;
                r_last   <= w_gnt1;
                r_result <= w_alu_y;
                r_zero   <= w_alu_zero;
            end
        end
    end

    assign rsp0_valid = (r_state == HOLD) & ~r_owner;
    assign rsp1_valid = (r_state == HOLD) &  r_owner;
    assign rsp_result = r_result;
    assign rsp_zero   = r_zero;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: accepted requests push expected
// results to a queue that is checked as responses are presented.
module tb_alu_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        req0_valid, req1_valid;
    logic        req0_ready, req1_ready;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic [2:0]  req0_op, req1_op;
    logic        rsp0_valid, rsp1_valid;
    logic        rsp0_ready, rsp1_ready;
    logic [31:0] rsp_result;
    logic        rsp_zero;

    typedef struct {
        logic        owner;
        logic [31:0] res;
        logic        zero;
    } exp_t;

    exp_t q[$];
    int   n_vec = 0;
    int   n_err = 0;

    alu_arbiter #(.N(32)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .req0_valid (req0_valid),
        .req1_valid (req1_valid),
        .req0_ready (req0_ready),
        .req1_ready (req1_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req0_op    (req0_op),
        .req1_op    (req1_op),
        .rsp0_valid (rsp0_valid),
        .rsp1_valid (rsp1_valid),
        .rsp0_ready (rsp0_ready),
        .rsp1_ready (rsp1_ready),
        .rsp_result (rsp_result),
        .rsp_zero   (rsp_zero)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] model(logic [31:0] a, logic [31:0] b,
                                          logic [2:0] op);
        case (op)
            3'd0: return a + b;
            3'd1: return a - b;
            3'd2: return a & b;
            3'd3: return a | b;
            3'd4: return a ^ b;
            3'd5: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'd6: return a << b[4:0];
            default: return a >> b[4:0];
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Compare presented response against the scoreboard head
    task automatic chk_rsp(input string tag);
        if (q.size() > 0) begin
            chk({tag, ".v0"}, 32'(rsp0_valid), 32'(q[0].owner == 1'b0));
            chk({tag, ".v1"}, 32'(rsp1_valid), 32'(q[0].owner == 1'b1));
            chk({tag, ".res"}, rsp_result, q[0].res);
            chk({tag, ".zero"}, 32'(rsp_zero), 32'(q[0].zero));
        end else begin
            chk({tag, ".v0"}, 32'(rsp0_valid), 32'd0);
            chk({tag, ".v1"}, 32'(rsp1_valid), 32'd0);
        end
    endtask

    // One clock: drive, check ready and response, update scoreboard
    task automatic step(input string tag,
                        input logic v0, input logic [31:0] a0,
                        input logic [31:0] b0, input logic [2:0] op0,
                        input logic v1, input logic [31:0] a1,
                        input logic [31:0] b1, input logic [2:0] op1,
                        input logic rr0, input logic rr1,
                        input logic er0, input logic er1);
        exp_t e;
        @(negedge clk);
        reset_n = 1'b1;
        req0_valid = v0; req0_a = a0; req0_b = b0; req0_op = op0;
        req1_valid = v1; req1_a = a1; req1_b = b1; req1_op = op1;
        rsp0_ready = rr0; rsp1_ready = rr1;
        #1;
        chk({tag, ".rdy0"}, 32'(req0_ready), 32'(er0));
        chk({tag, ".rdy1"}, 32'(req1_ready), 32'(er1));
        chk_rsp(tag);
        if (q.size() > 0)
            if ((q[0].owner == 1'b0 && rr0) || (q[0].owner == 1'b1 && rr1))
                void'(q.pop_front());
        if (er0) begin
            e.owner = 1'b0; e.res = model(a0, b0, op0); e.zero = (e.res == 0);
            q.push_back(e);
        end
        if (er1) begin
            e.owner = 1'b1; e.res = model(a1, b1, op1); e.zero = (e.res == 0);
            q.push_back(e);
        end
    endtask

    task automatic idle(input string tag);
        step(tag, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0);
    endtask

    // Reset cycle with both requesters valid and consuming
    task automatic rst_cycle(input string tag);
        @(negedge clk);
        reset_n = 1'b0;
        req0_valid = 1'b1; req0_a = 32'd1; req0_b = 32'd2; req0_op = 3'd0;
        req1_valid = 1'b1; req1_a = 32'd3; req1_b = 32'd4; req1_op = 3'd0;
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        #1;
        chk({tag, ".rdy0"}, 32'(req0_ready), 32'd0);
        chk({tag, ".rdy1"}, 32'(req1_ready), 32'd0);
        @(posedge clk);
        #1;
        q.delete();
        chk({tag, ".v0"}, 32'(rsp0_valid), 32'd0);
        chk({tag, ".v1"}, 32'(rsp1_valid), 32'd0);
        chk({tag, ".res"}, rsp_result, 32'd0);
        chk({tag, ".zero"}, 32'(rsp_zero), 32'd0);
    endtask

    initial begin
        reset_n = 1'b0;
        req0_valid = 0; req1_valid = 0;
        req0_a = 0; req0_b = 0; req1_a = 0; req1_b = 0;
        req0_op = 0; req1_op = 0;
        rsp0_ready = 0; rsp1_ready = 0;

        rst_cycle("rst_a");
        rst_cycle("rst_b");

        // single add 5+3
        step("add", 1, 5, 3, 3'd0, 0, 0, 0, 0, 1, 0, 1, 0);
        idle("add_rsp");

        // sub to zero, then back-to-back slt -1 < 1
        step("sub", 0, 0, 0, 0, 1, 7, 7, 3'd1, 0, 1, 0, 1);
        step("slt", 0, 0, 0, 0, 1, 32'hFFFF_FFFF, 1, 3'd5, 0, 1, 0, 1);
        idle("slt_rsp");

        // tie fairness after reset: 0,1,0,1
        rst_cycle("rst_tie");
        step("tie1", 1, 32'h10, 32'h3, 3'd0, 1, 32'hF0, 32'h3C, 3'd2,
             1, 1, 1, 0);
        step("tie2", 1, 32'hAA, 32'h55, 3'd4, 1, 32'hF0, 32'h3C, 3'd2,
             1, 1, 0, 1);
        step("tie3", 1, 32'h80, 32'd4, 3'd7, 1, 32'h9, 32'h9, 3'd1,
             1, 1, 1, 0);
        step("tie4", 1, 32'h80, 32'd4, 3'd7, 1, 32'h1, 32'h2, 3'd3,
             1, 1, 0, 1);
        idle("tie_end");

        // backpressure: 0xFF held 5 cycles while req1 waits
        step("bp_acc", 1, 32'hF0, 32'h0F, 3'd3, 0, 0, 0, 0, 0, 0, 1, 0);
        for (int i = 0; i < 5; i++)
            step("bp_hold", 0, 0, 0, 0, 1, 32'(i * 17), 32'(i + 1), 3'(i),
                 0, 0, 0, 0);
        step("bp_rel", 0, 0, 0, 0, 1, 32'd100, 32'd1, 3'd1, 1, 0, 0, 1);
        idle("bp_rsp");

        // reset while result held for requester 0
        step("mh_acc", 1, 32'd9, 32'd1, 3'd0, 0, 0, 0, 0, 0, 0, 1, 0);
        step("mh_hold", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        rst_cycle("mh_rst");
        step("mh_tie", 1, 32'd2, 32'd2, 3'd0, 1, 32'd3, 32'd3, 3'd0,
             1, 1, 1, 0);
        idle("mh_rsp");

        // wrap-around add and oversized shift amount
        step("wrap", 1, 32'hFFFF_FFFF, 1, 3'd0, 0, 0, 0, 0, 1, 0, 1, 0);
        step("sll", 1, 1, 32'h25, 3'd6, 0, 0, 0, 0, 1, 0, 1, 0);
        idle("sll_rsp");
        idle("end");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 The block SHALL have parameter N, default 32, meaning operand/result width in bits (N >= 8).
REQ-002 The block SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 The block SHALL have port reset_n  input  1  synchronous, active-low reset.
REQ-004 The block SHALL have ports req0_valid / req1_valid  input  1  requester i presents an operation.
REQ-005 The block SHALL have ports req0_ready / req1_ready  output  1  operation of requester i accepted this cycle.
REQ-006 The block SHALL have ports req0_a, req0_b / req1_a, req1_b  input  N  operands of requester i.
REQ-007 The block SHALL have ports req0_op / req1_op  input  3  ALU control code of requester i.
REQ-008 The block SHALL have ports rsp0_valid / rsp1_valid  output  1  result for requester i held.
REQ-009 The block SHALL have ports rsp0_ready / rsp1_ready  input  1  requester i consumes its result.
REQ-010 The block SHALL have ports rsp_result  output  N and rsp_zero  output  1, the held result and zero flag, shared by both requesters.

Function
REQ-011 The block SHALL time-share one ALU between two requesters; op codes: 000 add, 001 sub, 010 and, 011 or, 100 xor, 101 slt (signed, result 0/1), 110 sll, 111 srl; shift amount b[4:0]; add/sub wrap modulo 2^N.
REQ-012 The FSM SHALL have states IDLE (no result held) and HOLD (one result held in the output register).
REQ-013 The block SHALL be able to accept a request when in IDLE, or when in HOLD and the rsp_ready of the current owner is 1 in the same cycle.
REQ-014 Request i SHALL be accepted when reqi_valid=1, the block can accept, and requester i wins arbitration; reqi_ready is combinational and is 1 only in that cycle.
REQ-015 Arbitration SHALL be round-robin: if only one valid, it wins; if both valid, the requester not granted most recently wins; the last-grant pointer updates only on acceptance.
REQ-016 On acceptance in cycle t, the ALU result and zero flag of the accepted operands SHALL be registered, and rspi_valid=1 with rsp_result/rsp_zero stable from cycle t+1 (latency 1).
REQ-017 rspi_valid SHALL stay 1 and rsp_result/rsp_zero SHALL hold unchanged until rspi_ready=1; the other requester's rsp_valid SHALL be 0.
REQ-018 On consume with no acceptance, the FSM SHALL go HOLD->IDLE; consume plus acceptance in the same cycle SHALL stay in HOLD with the new owner/result (throughput 1 op/cycle).
REQ-019 rspi_ready while rspi_valid=0 SHALL be ignored.
REQ-020 Operand or op changes while reqi_valid=1 and reqi_ready=0 SHALL have no effect on state.
REQ-021 rsp_zero SHALL be 1 iff the registered result is all zeros.

Reset
REQ-022 With reset_n=0 at a rising edge: state=IDLE, rsp0_valid=rsp1_valid=0, rsp_result=0, rsp_zero=0, and the last-grant pointer set so that requester 0 wins the first tie.
REQ-023 reset_n=0 SHALL override any same-cycle acceptance or consume; a held result SHALL be discarded when reset occurs mid-HOLD.
REQ-024 req0_ready and req1_ready SHALL be 0 while reset_n=0.

Structure
REQ-025 The op-code enum (ALU control encodings) and FSM state typedef SHALL live in shared package alu_pkg.
REQ-026 The block SHALL instantiate exactly one existing alu sub-module (parameter N) fed by a grant-selected operand mux; no second ALU.

Verification
REQ-027 Single add: req0 a=5, b=3, op=000, rsp0_ready=1 -> req0_ready=1 at t; rsp0_valid=1, rsp_result=8, rsp_zero=0 at t+1.
REQ-028 Sub to zero: req1 a=7, b=7, op=001 -> rsp1_valid=1, rsp_result=0, rsp_zero=1; slt a=-1, b=1 -> result 1.
REQ-029 Tie fairness: both valid continuously, rsp_ready=1, after reset -> grants 0,1,0,1; results return in that order, one per cycle.
REQ-030 Backpressure: result 0x0000_00FF held with rsp0_ready=0 for 5 cycles while req1 valid -> rsp_result stable, req1_ready=0; rsp0_ready=1 -> req1 accepted the same cycle.
REQ-031 Reset mid-HOLD: reset_n=0 for one cycle while rsp0_valid=1 -> next cycle both rsp_valid=0, rsp_result=0; the next tie grants requester 0.
REQ-032 Wrap/shift: a=0xFFFF_FFFF, b=1, op=000 -> 0, zero=1; a=1, b=0x25, op=110 -> 0x20.
